// File: rtl/counter_pkg.sv
// Shared definitions for the counter scheduler: mode codes, FSM encoding, default widths.
package counter_pkg;

   localparam int unsigned DEF_NUM_W = 4;
   localparam int unsigned DEF_LEN_W = 4;

   // Counter mode codes driven on modo
   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DN   = 2'b01;
   localparam logic [1:0] MODE_DN3  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last winner, reset favours A first.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       req_a,
   input  logic       req_b,
   input  logic       adv,
   output logic [1:0] gnt_c
);

   logic last_b_q;

   // One-hot grant: bit 0 = A, bit 1 = B; ties go to the side that did not win last
   always_comb begin
      gnt_c = 2'b00;
      if (req_a && req_b) begin
         gnt_c = last_b_q ? 2'b01 : 2'b10;
      end else if (req_a) begin
         gnt_c = 2'b01;
      end else if (req_b) begin
         gnt_c = 2'b10;
      end
   end

   // Pointer moves only when the scheduler actually takes a grant
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         last_b_q <= 1'b1;
      end else if (adv) begin
         last_b_q <= gnt_c[1];
      end
   end

endmodule

// File: rtl/counter_sched.sv
// Job scheduler for the shared up/down counter: arbitrates A/B, drives enable/modo/D,
// returns the final Q. Optional macro COUNTER_SCHED_RCO_STOP_EN ends a run on the first rco.
module counter_sched
   import counter_pkg::*;
#(
   parameter int unsigned NUM_W = DEF_NUM_W,
   parameter int unsigned LEN_W = DEF_LEN_W
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [1:0]       mode_a,
   input  logic [1:0]       mode_b,
   input  logic [NUM_W-1:0] data_a,
   input  logic [NUM_W-1:0] data_b,
   input  logic [LEN_W-1:0] len_a,
   input  logic [LEN_W-1:0] len_b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             done_a,
   output logic             done_b,
   output logic [NUM_W-1:0] result,
   output logic             rco_seen,
   output logic             enable,
   output logic [1:0]       modo,
   output logic [NUM_W-1:0] D,
   input  logic [NUM_W-1:0] Q,
   input  logic             rco
);

   state_t           state;
   logic [1:0]       mode_q;
   logic [NUM_W-1:0] data_q;
   logic [LEN_W-1:0] cnt_q;
   logic             owner_b_q;
   logic [NUM_W-1:0] result_q;

   logic [1:0]       arb_gnt_c;
   logic             arb_adv_c;
   logic             run_cycle_c;
   logic             stop_c;

   // New jobs are accepted from IDLE and from DONE so back-to-back jobs lose no cycle
   assign arb_adv_c   = ((state == ST_IDLE) || (state == ST_DONE)) && (req_a || req_b);

   // The counter is in a counting cycle (not the preload cycle) right now
   assign run_cycle_c = enable && (modo != MODE_LOAD);

`ifdef COUNTER_SCHED_RCO_STOP_EN
   assign stop_c = run_cycle_c && rco;
`else
   assign stop_c = 1'b0;
`endif

   // The counter's final value only appears in the done cycle, so forward Q then
   assign result = (done_a || done_b) ? Q : result_q;

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_L (reset_L),
      .req_a   (req_a),
      .req_b   (req_b),
      .adv     (arb_adv_c),
      .gnt_c   (arb_gnt_c)
   );

   // Job FSM; counter controls are registered one state ahead of the cycle they act in
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state     <= ST_IDLE;
         gnt_a     <= 1'b0;
         gnt_b     <= 1'b0;
         done_a    <= 1'b0;
         done_b    <= 1'b0;
         rco_seen  <= 1'b0;
         enable    <= 1'b0;
         modo      <= MODE_UP;
         D         <= '0;
         result_q  <= '0;
         mode_q    <= MODE_UP;
         data_q    <= '0;
         cnt_q     <= '0;
         owner_b_q <= 1'b0;
      end else begin
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
         done_a <= 1'b0;
         done_b <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (state == ST_DONE) begin
                  result_q <= Q;
               end
               if (arb_adv_c) begin
                  gnt_a     <= arb_gnt_c[0];
                  gnt_b     <= arb_gnt_c[1];
                  owner_b_q <= arb_gnt_c[1];
                  mode_q    <= arb_gnt_c[1] ? mode_b : mode_a;
                  data_q    <= arb_gnt_c[1] ? data_b : data_a;
                  cnt_q     <= arb_gnt_c[1] ? len_b  : len_a;
                  state     <= ST_LOAD;
               end else begin
                  state     <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               enable   <= 1'b1;
               modo     <= MODE_LOAD;
               D        <= data_q;
               rco_seen <= 1'b0;
               if (mode_q == MODE_LOAD) begin
                  cnt_q <= '0;
               end
               state    <= ST_RUN;
            end
            ST_RUN: begin
               if (run_cycle_c && rco) begin
                  rco_seen <= 1'b1;
               end
               if ((cnt_q == '0) || stop_c) begin
                  enable <= 1'b0;
                  modo   <= MODE_UP;
                  D      <= '0;
                  done_a <= !owner_b_q;
                  done_b <= owner_b_q;
                  state  <= ST_DONE;
               end else begin
                  enable <= 1'b1;
                  modo   <= mode_q;
                  D      <= data_q;
                  cnt_q  <= cnt_q - LEN_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched with a behavioural 4-bit up/down counter attached.
module tb_counter_sched;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       req_a, req_b;
   logic [1:0] mode_a, mode_b;
   logic [3:0] data_a, data_b, len_a, len_b;
   logic       gnt_a, gnt_b, done_a, done_b;
   logic [3:0] result;
   logic       rco_seen, enable;
   logic [1:0] modo;
   logic [3:0] D;
   logic [3:0] q;
   logic       rco_m;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       own_b;
      logic [1:0] mode;
      logic [3:0] data;
      logic [3:0] len;
      int         lat;
      logic [3:0] res;
      logic       rco;
      int         runs;
   } vec_t;

   vec_t vecs [7];
   vec_t resub;
   logic [1:0] conf_exp [4];

   always #5 clk = ~clk;

   counter_sched dut (
      .clk(clk), .reset_L(reset_L),
      .req_a(req_a), .req_b(req_b),
      .mode_a(mode_a), .mode_b(mode_b),
      .data_a(data_a), .data_b(data_b),
      .len_a(len_a), .len_b(len_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b),
      .done_a(done_a), .done_b(done_b),
      .result(result), .rco_seen(rco_seen),
      .enable(enable), .modo(modo), .D(D),
      .Q(q), .rco(rco_m)
   );

   // Reference counter: 00 up, 01 down, 10 down by 3, 11 load D
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         q <= 4'h0;
      end else if (enable) begin
         case (modo)
            2'b00:   q <= q + 4'd1;
            2'b01:   q <= q - 4'd1;
            2'b10:   q <= q - 4'd3;
            default: q <= D;
         endcase
      end
   end

   assign rco_m = enable && (((modo == 2'b00) && (q == 4'hF)) ||
                             ((modo == 2'b01) && (q == 4'h0)) ||
                             ((modo == 2'b10) && (q < 4'd3)));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_gnt"},    32'({gnt_a, gnt_b}), 32'd0);
      chk({name, "_done"},   32'({done_a, done_b}), 32'd0);
      chk({name, "_enable"}, 32'(enable), 32'd0);
      chk({name, "_modo"},   32'(modo), 32'd0);
      chk({name, "_D"},      32'(D), 32'd0);
      chk({name, "_result"}, 32'(result), 32'd0);
      chk({name, "_rco"},    32'(rco_seen), 32'd0);
   endtask

   // Submit one job from a lone requester and check grant, load, run length, done and result
   task automatic run_job(input vec_t v, input int idx);
      string tag;
      int    cyc;
      int    runs;
      bit    got;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      if (v.own_b) begin
         req_b = 1'b1; mode_b = v.mode; data_b = v.data; len_b = v.len;
         mode_a = ~v.mode; data_a = ~v.data; len_a = ~v.len;
      end else begin
         req_a = 1'b1; mode_a = v.mode; data_a = v.data; len_a = v.len;
         mode_b = ~v.mode; data_b = ~v.data; len_b = ~v.len;
      end
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         if (gnt_a || gnt_b) got = 1'b1;
         else cyc++;
      end
      chk({tag, "_gnt_seen"}, 32'(got), 32'd1);
      chk({tag, "_gnt_owner"}, 32'({gnt_a, gnt_b}), v.own_b ? 32'd1 : 32'd2);
      req_a = 1'b0;
      req_b = 1'b0;
      got = 1'b0;
      cyc = 0;
      runs = 0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk({tag, "_load_en"},   32'(enable), 32'd1);
            chk({tag, "_load_modo"}, 32'(modo), 32'd3);
            chk({tag, "_load_D"},    32'(D), 32'(v.data));
         end
         if (enable && (modo != 2'b11)) runs++;
         if (done_a || done_b) got = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(got), 32'd1);
      chk({tag, "_latency"},   32'(cyc), 32'(v.lat));
      chk({tag, "_runs"},      32'(runs), 32'(v.runs));
      chk({tag, "_done_own"},  32'({done_a, done_b}), v.own_b ? 32'd1 : 32'd2);
      chk({tag, "_result"},    32'(result), 32'(v.res));
      chk({tag, "_rco_seen"},  32'(rco_seen), 32'(v.rco));
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'({done_a, done_b}), 32'd0);
      chk({tag, "_result_hold"}, 32'(result), 32'(v.res));
   endtask

   initial begin
      //          own   mode   data   len  lat  res    rco  runs
      vecs[0] = '{1'b0, 2'd0, 4'd3,  4'd5,  7,  4'd8,  1'b0, 5};
      vecs[1] = '{1'b1, 2'd3, 4'd9,  4'd7,  2,  4'd9,  1'b0, 0};
`ifdef COUNTER_SCHED_RCO_STOP_EN
      vecs[2] = '{1'b0, 2'd0, 4'd14, 4'd4,  4,  4'd0,  1'b1, 2};
`else
      vecs[2] = '{1'b0, 2'd0, 4'd14, 4'd4,  6,  4'd2,  1'b1, 4};
`endif
      vecs[3] = '{1'b1, 2'd1, 4'd2,  4'd3,  5,  4'd15, 1'b1, 3};
      vecs[4] = '{1'b0, 2'd2, 4'd10, 4'd3,  5,  4'd1,  1'b0, 3};
`ifdef COUNTER_SCHED_RCO_STOP_EN
      vecs[5] = '{1'b0, 2'd1, 4'd8,  4'd15, 11, 4'd15, 1'b1, 9};
`else
      vecs[5] = '{1'b0, 2'd1, 4'd8,  4'd15, 17, 4'd9,  1'b1, 15};
`endif
      vecs[6] = '{1'b1, 2'd0, 4'd5,  4'd0,  2,  4'd5,  1'b0, 0};
      resub   = '{1'b0, 2'd0, 4'd0,  4'd10, 12, 4'd10, 1'b0, 10};
      conf_exp[0] = 2'b10;
      conf_exp[1] = 2'b01;
      conf_exp[2] = 2'b10;
      conf_exp[3] = 2'b01;

      // Reset held with a pending request: nothing may be granted
      reset_L = 1'b0;
      req_a = 1'b1; req_b = 1'b0;
      mode_a = 2'd3; data_a = 4'd6; len_a = 4'd0;
      mode_b = 2'd0; data_b = 4'd0; len_b = 4'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs($sformatf("rst%0d", i));
      end
      reset_L = 1'b1;
      @(negedge clk);
      chk("rst_release_gnt", 32'({gnt_a, gnt_b}), 32'd2);
      req_a = 1'b0;
      begin
         bit got;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (done_a) got = 1'b1;
         end
         chk("rst_job_done", 32'(got), 32'd1);
         chk("rst_job_result", 32'(result), 32'd6);
      end

      // Directed single-requester jobs
      for (int i = 0; i < 7; i++) begin
         run_job(vecs[i], i);
      end

      // Both requesters together, twice: pointer alternates the winner
      @(negedge clk);
      mode_a = 2'd3; data_a = 4'd1; len_a = 4'd0;
      mode_b = 2'd3; data_b = 4'd2; len_b = 4'd0;
      req_a = 1'b1; req_b = 1'b1;
      begin
         int ngr;
         int cyc;
         ngr = 0;
         cyc = 0;
         while (ngr < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (gnt_a || gnt_b) begin
               chk($sformatf("conflict_gnt%0d", ngr), 32'({gnt_a, gnt_b}), 32'(conf_exp[ngr]));
               if (gnt_a) req_a = 1'b0;
               else req_b = 1'b0;
               ngr++;
               if (ngr == 2) begin
                  req_a = 1'b1;
                  req_b = 1'b1;
               end
            end
         end
         chk("conflict_count", 32'(ngr), 32'd4);
      end
      req_a = 1'b0;
      req_b = 1'b0;
      repeat (5) @(negedge clk);

      // Reset in the middle of a run: controls drop at once, no done pulse
      mode_a = 2'd0; data_a = 4'd0; len_a = 4'd10;
      req_a = 1'b1;
      begin
         bit got;
         got = 1'b0;
         for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt_a) got = 1'b1;
         end
         chk("mid_gnt_seen", 32'(got), 32'd1);
      end
      req_a = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_running", 32'(enable), 32'd1);
      reset_L = 1'b0;
      #1;
      check_idle_outputs("mid_rst");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("mid_no_done%0d", i), 32'({done_a, done_b, enable}), 32'd0);
      end
      reset_L = 1'b1;
      run_job(resub, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
